// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory. It takes a framed byte stream (COUNT_HI, COUNT_LO,
// payload, CSUM), writes big-endian words into imem and holds the core in reset until the image checks out.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  // state    | meaning
  // S_CNT_HI | waiting for COUNT high byte
  // S_CNT_LO | waiting for COUNT low byte, range-check COUNT
  // S_DATA   | assembling payload words and writing imem
  // S_CSUM   | comparing checksum byte against XOR accumulator
  // S_DONE   | image good, core released (terminal)
  // S_ERROR  | frame rejected, core held (terminal)
  typedef enum logic [2:0] {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  state_t                state, state_nxt;
  logic [7:0]            cnt_hi;
  logic [7:0]            acc;
  logic [15:0]           words_left;
  logic [1:0]            byte_idx;
  logic [23:0]           word_sr;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  accept;
  logic [15:0]           count;

  assign count    = {cnt_hi, in_data};
  assign in_ready = (state == S_CNT_HI || state == S_CNT_LO || state == S_DATA || state == S_CSUM)
                    && !restart;
  assign accept   = in_valid && in_ready;
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);
  assign cpu_reset = !done;

  always_ff @(posedge clk) begin
    if (reset || restart) state <= S_CNT_HI;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_CNT_HI: state_nxt = S_CNT_LO;
        S_CNT_LO: begin
          if (count == 16'd0)                  state_nxt = S_CSUM;
          else if ({16'd0, count} > MAX_WORDS) state_nxt = S_ERROR;
          else                                 state_nxt = S_DATA;
        end
        S_DATA: begin
          if (byte_idx == 2'd3 && words_left == 16'd1) state_nxt = S_CSUM;
        end
        S_CSUM:   state_nxt = (in_data == acc) ? S_DONE : S_ERROR;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_hi     <= 8'h00;
      acc        <= 8'h00;
      words_left <= 16'd0;
      byte_idx   <= 2'd0;
      word_sr    <= 24'd0;
      widx       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        if (state != S_CSUM) acc <= acc ^ in_data;
        case (state)
          S_CNT_HI: cnt_hi <= in_data;
          S_CNT_LO: words_left <= count;
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            word_sr  <= {word_sr[15:0], in_data};
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= widx;
              imem_wdata <= {word_sr, in_data};
              widx       <= widx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
              words_left <= words_left - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad frames, empty and oversize frames,
// throttled input, mid-frame reset and restart from S_DONE.
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  fr[$];

  imem_boot_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Offer one byte and return #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=in_ready_low expected=accept");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Sends a whole frame; after every payload byte checks the write strobe
  // (and address/data on each 4th byte).
  task automatic send_frame(input logic [7:0] f[$], input int gap);
    int pidx;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i]);
      if (i >= 2 && i < f.size() - 1) begin
        pidx = i - 2;
        if (pidx % 4 == 3) begin
          check("we_after_4th", {31'd0, imem_we}, 32'd1);
          check("we_addr", {24'd0, imem_addr}, pidx / 4);
          check("we_data", imem_wdata, {f[i-3], f[i-2], f[i-1], f[i]});
        end else begin
          check("we_idle", {31'd0, imem_we}, 32'd0);
        end
      end
      if (i == f.size() - 2) check("cpu_reset_before_csum", {31'd0, cpu_reset}, 32'd1);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_cpu, input logic e_rdy);
    check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, e_cpu});
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, e_rdy});
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, {24'd0, wr_addr[0]}, 32'd0);
      check({tag, "_d0"}, wr_data[0], 32'h20080005);
      check({tag, "_a1"}, {24'd0, wr_addr[1]}, 32'd1);
      check({tag, "_d1"}, wr_data[1], 32'hAC080000);
    end
  endtask

  initial begin
    reset    = 1'b1;
    restart  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();

    // XOR of 00 02 20 08 00 05 AC 08 00 00 is 8B
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
    send_frame(fr, 0);
    check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
    check_two_writes("good");

    do_reset();
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h2C};
    send_frame(fr, 0);
    check_status("badcs", 1'b0, 1'b1, 1'b1, 1'b0);
    check_two_writes("badcs");

    do_reset();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(fr, 0);
    check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);
    check("empty_nwr", wr_addr.size(), 32'd0);

    do_reset();
    send_byte(8'h01);
    check_status("big_hi", 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h01);
    check_status("big", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_status("big_hold", 1'b0, 1'b1, 1'b1, 1'b0);

    do_reset();
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
    send_frame(fr, 1);
    check_status("toggle", 1'b1, 1'b0, 1'b0, 1'b0);
    check_two_writes("toggle");

    do_reset();
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
    foreach (fr[i]) send_byte(fr[i]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_status("midrst", 1'b0, 1'b0, 1'b1, 1'b1);
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
    send_frame(fr, 0);
    @(posedge clk); #1;
    check("midrst_nwr", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      check("midrst_a0", {24'd0, wr_addr[0]}, 32'd0);
      check("midrst_a1", {24'd0, wr_addr[1]}, 32'd0);
      check("midrst_a2", {24'd0, wr_addr[2]}, 32'd1);
      check("midrst_d2", wr_data[2], 32'hAC080000);
    end
    check_status("midrst_end", 1'b1, 1'b0, 1'b0, 1'b0);

    in_valid = 1'b1;
    in_data  = 8'h00;
    restart  = 1'b1;
    #1;
    check("restart_rdy_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
    wr_addr.delete();
    wr_data.delete();
    send_frame(fr, 0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    check_two_writes("reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
